// File: rtl/lift_pkg.sv
// Shared types and defaults for the lifting DMA engine.
package lift_pkg;

   localparam int unsigned AW_DEF = 24;
   localparam int unsigned DW_DEF = 16;
   localparam int unsigned CW     = 16;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD_L = 3'd1,
      ST_RD_S = 3'd2,
      ST_RD_R = 3'd3,
      ST_LIFT = 3'd4,
      ST_WR   = 3'd5,
      ST_NEXT = 3'd6,
      ST_FIN  = 3'd7
   } state_t;

   // True for states that own an SDRAM host access
   function automatic logic is_access(input state_t s);
      return (s == ST_RD_L) || (s == ST_RD_S) || (s == ST_RD_R) || (s == ST_WR);
   endfunction

endpackage

// File: rtl/lift_hreq.sv
// SDRAM host request holder: raises rd/wr with a frozen address and drops it after hdone.
module lift_hreq import lift_pkg::*; #(
   parameter int unsigned AW = AW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          issue_c,
   input  logic          wr_c,
   input  logic [AW-1:0] addr_c,
   input  logic          hdone_i,
   output logic          rd_o,
   output logic          wr_o,
   output logic [AW-1:0] addr_o,
   output logic          ack_c
);

   logic          rd_q, rd_d;
   logic          wr_q, wr_d;
   logic [AW-1:0] addr_q, addr_d;

   // Launch when idle, hold while outstanding, release on completion
   always_comb begin
      rd_d   = rd_q;
      wr_d   = wr_q;
      addr_d = addr_q;
      ack_c  = (rd_q | wr_q) & hdone_i;
      if (rd_q | wr_q) begin
         if (hdone_i) begin
            rd_d = 1'b0;
            wr_d = 1'b0;
         end
      end else if (issue_c) begin
         rd_d   = ~wr_c;
         wr_d   = wr_c;
         addr_d = addr_c;
      end
   end

   // Request registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q   <= 1'b0;
         wr_q   <= 1'b0;
         addr_q <= '0;
      end else begin
         rd_q   <= rd_d;
         wr_q   <= wr_d;
         addr_q <= addr_d;
      end
   end

   assign rd_o   = rd_q;
   assign wr_o   = wr_q;
   assign addr_o = addr_q;

endmodule

// File: rtl/lift_dma.sv
// Lifting DMA: per output, reads three neighbours, runs the lift and writes the result.
module lift_dma import lift_pkg::*; #(
   parameter int unsigned AW       = AW_DEF,
   parameter int unsigned DW       = DW_DEF,
   parameter int unsigned LIFT_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start_i,
   input  logic [AW-1:0] src_i,
   input  logic [AW-1:0] dst_i,
   input  logic [CW-1:0] count_i,
   output logic          busy_o,
   output logic          done_o,
   output logic          rd_o,
   output logic          wr_o,
   output logic [AW-1:0] addr_o,
   output logic [DW-1:0] wdata_o,
   input  logic [DW-1:0] rdata_i,
   input  logic          hdone_i,
   output logic [DW-1:0] l_s,
   output logic [DW-1:0] s_s,
   output logic [DW-1:0] r_s,
   input  logic [DW-1:0] res_s
);

   localparam int unsigned LW = (LIFT_LAT > 1) ? $clog2(LIFT_LAT) : 1;

   state_t        state_q, state_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [AW-1:0] src_q, src_d;
   logic [AW-1:0] dst_q, dst_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] idx_q, idx_d;
   logic [LW-1:0] lat_q, lat_d;
   logic [DW-1:0] l_q, l_d;
   logic [DW-1:0] s_q, s_d;
   logic [DW-1:0] r_q, r_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [AW-1:0] acc_addr_c;
   logic          ack_c;
   logic          lat_last_c;

   assign lat_last_c = (lat_q == LW'(LIFT_LAT - 1));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start_i) state_d = (count_i == '0) ? ST_FIN : ST_RD_L;
         ST_RD_L: if (ack_c) state_d = ST_RD_S;
         ST_RD_S: if (ack_c) state_d = ST_RD_R;
         ST_RD_R: if (ack_c) state_d = ST_LIFT;
         ST_LIFT: if (lat_last_c) state_d = ST_WR;
         ST_WR:   if (ack_c) state_d = ST_NEXT;
         ST_NEXT: state_d = (CW'(idx_q + CW'(1)) == cnt_q) ? ST_FIN : ST_RD_L;
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Output and datapath next values
   always_comb begin
      busy_d  = busy_q;
      done_d  = 1'b0;
      src_d   = src_q;
      dst_d   = dst_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      lat_d   = lat_q;
      l_d     = l_q;
      s_d     = s_q;
      r_d     = r_q;
      wdata_d = wdata_q;
      case (state_q)
         ST_IDLE: if (start_i) begin
            src_d  = src_i;
            dst_d  = dst_i;
            cnt_d  = count_i;
            idx_d  = '0;
            busy_d = 1'b1;
         end
         ST_RD_L: if (ack_c) l_d = rdata_i;
         ST_RD_S: if (ack_c) s_d = rdata_i;
         ST_RD_R: if (ack_c) begin
            r_d   = rdata_i;
            lat_d = '0;
         end
         ST_LIFT: begin
            lat_d = LW'(lat_q + LW'(1));
            if (lat_last_c) wdata_d = res_s;
         end
         ST_NEXT: idx_d = CW'(idx_q + CW'(1));
         ST_FIN: begin
            done_d = 1'b1;
            busy_d = 1'b0;
         end
         default: ;
      endcase
   end

   // Host address for the access owned by the current state (wraps modulo 2^AW)
   always_comb begin
      acc_addr_c = '0;
      case (state_q)
         ST_RD_L: acc_addr_c = AW'(src_q + AW'(idx_q));
         ST_RD_S: acc_addr_c = AW'(src_q + AW'(idx_q) + AW'(1));
         ST_RD_R: acc_addr_c = AW'(src_q + AW'(idx_q) + AW'(2));
         ST_WR:   acc_addr_c = AW'(dst_q + AW'(idx_q));
         default: acc_addr_c = '0;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         src_q   <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         lat_q   <= '0;
         l_q     <= '0;
         s_q     <= '0;
         r_q     <= '0;
         wdata_q <= '0;
      end else begin
         busy_q  <= busy_d;
         done_q  <= done_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         lat_q   <= lat_d;
         l_q     <= l_d;
         s_q     <= s_d;
         r_q     <= r_d;
         wdata_q <= wdata_d;
      end
   end

   lift_hreq #(.AW(AW)) u_hreq (
      .clk     (clk),
      .rst     (rst),
      .issue_c (is_access(state_q)),
      .wr_c    (state_q == ST_WR),
      .addr_c  (acc_addr_c),
      .hdone_i (hdone_i),
      .rd_o    (rd_o),
      .wr_o    (wr_o),
      .addr_o  (addr_o),
      .ack_c   (ack_c)
   );

   assign busy_o  = busy_q;
   assign done_o  = done_q;
   assign wdata_o = wdata_q;
   assign l_s     = l_q;
   assign s_s     = s_q;
   assign r_s     = r_q;

endmodule
